// File: rtl/systolic_pkg.sv
// Shared constants and types for the 3x3 systolic matmul slice
// (operand feeder, PE array, result drain).
package systolic_pkg;

    localparam int N            = 3;
    localparam int DW           = 8;
    localparam int STREAM_BEATS = 3 * N - 2;
    localparam int TW           = $clog2(3 * N - 1);
    localparam int RW           = $clog2(N);
    localparam int LD_ROW_W     = 2;

    localparam logic LD_SEL_A = 1'b0;
    localparam logic LD_SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/systolic_operand_feeder_if.sv
// Host load/start bus plus array-edge outputs of the operand feeder.
interface systolic_operand_feeder_if;
    import systolic_pkg::*;

    logic                ld_valid;
    logic                ld_ready;
    logic                ld_sel;
    logic [LD_ROW_W-1:0] ld_row;
    logic [N*DW-1:0]     ld_data;
    logic                start;
    logic                feed_stall;
    logic [N*DW-1:0]     a_edge;
    logic [N*DW-1:0]     b_edge;
    logic                edge_valid;
    logic                acc_clear;
    logic                busy;
    logic                done;
    logic                start_err;

    modport master (
        output ld_valid, ld_sel, ld_row, ld_data, start, feed_stall,
        input  ld_ready, a_edge, b_edge, edge_valid, acc_clear, busy, done, start_err
    );

    modport slave (
        input  ld_valid, ld_sel, ld_row, ld_data, start, feed_stall,
        output ld_ready, a_edge, b_edge, edge_valid, acc_clear, busy, done, start_err
    );

endinterface

// File: rtl/operand_bank.sv
// NxN operand register file: whole-row writes, N element-addressed read ports,
// and a per-row loaded mask.
module operand_bank
    import systolic_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [N*DW-1:0] wr_data,
    input  logic [RW-1:0]   rd_row [N],
    input  logic [RW-1:0]   rd_col [N],
    output logic [DW-1:0]   rd_data [N],
    output logic [N-1:0]    mask
);

    logic [DW-1:0] mem [N][N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mem[r][c] <= '0;
        end else if (wr_en) begin
            mask[wr_row] <= 1'b1;
            for (int c = 0; c < N; c++)
                mem[wr_row][c] <= wr_data[c*DW +: DW];
        end
    end

    always_comb begin
        for (int p = 0; p < N; p++)
            rd_data[p] = mem[rd_row[p]][rd_col[p]];
    end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Holds matrices A and B and streams them diagonally skewed onto the
// left (A) and top (B) edges of the systolic array.
//
// state  | meaning
// IDLE   | accept row loads, wait for start
// CLEAR  | issue one acc_clear beat to the PEs
// STREAM | issue skew beats t = 0 .. 3N-3
// DONE   | one-cycle completion pulse
module systolic_operand_feeder
    import systolic_pkg::*;
(
    input logic                        clk,
    input logic                        reset,
    systolic_operand_feeder_if.slave   bus
);

    localparam logic [TW-1:0] T_LAST = TW'(STREAM_BEATS - 1);

    feeder_state_t   state, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [N*DW-1:0] a_edge_q, a_edge_d, b_edge_q, b_edge_d;
    logic            edge_valid_q, edge_valid_d;
    logic            acc_clear_q, acc_clear_d;
    logic            done_q, done_d;
    logic            start_err_q, start_err_d;

    logic [N-1:0]    a_mask, b_mask;
    logic            masks_full, ld_fire;
    logic [TW-1:0]   lane_k [N];
    logic [N-1:0]    lane_live;
    logic [RW-1:0]   a_rd_row [N], a_rd_col [N], b_rd_row [N], b_rd_col [N];
    logic [DW-1:0]   a_rd [N], b_rd [N];
    logic [N*DW-1:0] skew_a, skew_b;

    assign masks_full = (&a_mask) && (&b_mask);
    assign ld_fire    = bus.ld_valid && (state == IDLE) && (bus.ld_row < LD_ROW_W'(N));

    operand_bank u_bank_a (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ld_fire && (bus.ld_sel == LD_SEL_A)),
        .wr_row  (bus.ld_row[RW-1:0]),
        .wr_data (bus.ld_data),
        .rd_row  (a_rd_row),
        .rd_col  (a_rd_col),
        .rd_data (a_rd),
        .mask    (a_mask)
    );

    operand_bank u_bank_b (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ld_fire && (bus.ld_sel == LD_SEL_B)),
        .wr_row  (bus.ld_row[RW-1:0]),
        .wr_data (bus.ld_data),
        .rd_row  (b_rd_row),
        .rd_col  (b_rd_col),
        .rd_data (b_rd),
        .mask    (b_mask)
    );

    // Lane l carries inner index k = t - l; lanes outside 0..N-1 emit zero.
    always_comb begin
        for (int l = 0; l < N; l++) begin
            lane_k[l]    = t_q - TW'(l);
            lane_live[l] = (t_q >= TW'(l)) && (lane_k[l] < TW'(N));
            a_rd_row[l]  = RW'(l);
            a_rd_col[l]  = lane_live[l] ? lane_k[l][RW-1:0] : '0;
            b_rd_row[l]  = lane_live[l] ? lane_k[l][RW-1:0] : '0;
            b_rd_col[l]  = RW'(l);
            skew_a[l*DW +: DW] = lane_live[l] ? a_rd[l] : '0;
            skew_b[l*DW +: DW] = lane_live[l] ? b_rd[l] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            t_q          <= '0;
            a_edge_q     <= '0;
            b_edge_q     <= '0;
            edge_valid_q <= 1'b0;
            acc_clear_q  <= 1'b0;
            done_q       <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            state        <= state_d;
            t_q          <= t_d;
            a_edge_q     <= a_edge_d;
            b_edge_q     <= b_edge_d;
            edge_valid_q <= edge_valid_d;
            acc_clear_q  <= acc_clear_d;
            done_q       <= done_d;
            start_err_q  <= start_err_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.start && masks_full) state_d = CLEAR;
            CLEAR:   if (!bus.feed_stall) state_d = STREAM;
            STREAM:  if (!bus.feed_stall && (t_q == T_LAST)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stalled beats hold t and edge data so the pending beat is re-issued intact.
    always_comb begin
        t_d          = t_q;
        a_edge_d     = a_edge_q;
        b_edge_d     = b_edge_q;
        edge_valid_d = 1'b0;
        acc_clear_d  = 1'b0;
        done_d       = 1'b0;
        start_err_d  = 1'b0;
        case (state)
            IDLE: begin
                a_edge_d    = '0;
                b_edge_d    = '0;
                start_err_d = bus.start && !masks_full;
            end
            CLEAR: if (!bus.feed_stall) begin
                acc_clear_d = 1'b1;
                a_edge_d    = '0;
                b_edge_d    = '0;
                t_d         = '0;
            end
            STREAM: if (!bus.feed_stall) begin
                edge_valid_d = 1'b1;
                a_edge_d     = skew_a;
                b_edge_d     = skew_b;
                if (t_q != T_LAST) t_d = t_q + 1'b1;
            end
            DONE: begin
                done_d   = 1'b1;
                a_edge_d = '0;
                b_edge_d = '0;
            end
            default: ;
        endcase
    end

    assign bus.a_edge     = a_edge_q;
    assign bus.b_edge     = b_edge_q;
    assign bus.edge_valid = edge_valid_q;
    assign bus.acc_clear  = acc_clear_q;
    assign bus.done       = done_q;
    assign bus.start_err  = start_err_q;
    assign bus.busy       = (state != IDLE);
    assign bus.ld_ready   = (state == IDLE);

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Scoreboard bench for systolic_operand_feeder: stimulus pushes expected
// clear/beat/done/error events, a negedge monitor pops and compares them.
module tb_systolic_operand_feeder;
    import systolic_pkg::*;

    typedef enum int {EV_CLEAR, EV_BEAT, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t        kind;
        int              cyc;
        logic [N*DW-1:0] a;
        logic [N*DW-1:0] b;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    systolic_operand_feeder_if bus ();

    systolic_operand_feeder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ev_t sb[$];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [DW-1:0] amat [N][N];
    logic [DW-1:0] bmat [N][N];
    bit am [N];
    bit bm [N];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*DW-1:0] ref_a(int t);
        logic [N*DW-1:0] r = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) r[i*DW +: DW] = amat[i][t-i];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] ref_b(int t);
        logic [N*DW-1:0] r = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) r[j*DW +: DW] = bmat[t-j][j];
        return r;
    endfunction

    function automatic bit all_loaded();
        bit f = 1'b1;
        for (int r = 0; r < N; r++) f = f & am[r] & bm[r];
        return f;
    endfunction

    function automatic logic [3:0] kind_flags(ev_kind_t k);
        case (k)
            EV_BEAT:  return 4'b1000;
            EV_CLEAR: return 4'b0100;
            EV_DONE:  return 4'b0010;
            default:  return 4'b0001;
        endcase
    endfunction

    task automatic push(input ev_kind_t k, input int c, input int t);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.a    = (k == EV_BEAT) ? ref_a(t) : '0;
        e.b    = (k == EV_BEAT) ? ref_b(t) : '0;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [3:0] flags;
        ev_t e;
        if (!reset) begin
            flags = {bus.edge_valid, bus.acc_clear, bus.done, bus.start_err};
            if (flags != 4'b0000) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {60'd0, flags}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", {60'd0, flags}, {60'd0, kind_flags(e.kind)});
                    check("event_cycle", cyc, e.cyc);
                    if (e.kind == EV_BEAT) begin
                        check("a_edge", bus.a_edge, e.a);
                        check("b_edge", bus.b_edge, e.b);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < N; r++) begin
            am[r] = 1'b0;
            bm[r] = 1'b0;
        end
    endtask

    task automatic model_write(input bit sel, input int row, input logic [N*DW-1:0] d);
        if (row < N) begin
            for (int c = 0; c < N; c++)
                if (sel) bmat[row][c] = d[c*DW +: DW];
                else     amat[row][c] = d[c*DW +: DW];
            if (sel) bm[row] = 1'b1;
            else     am[row] = 1'b1;
        end
    endtask

    task automatic load_row(input bit sel, input int row, input logic [N*DW-1:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_sel   = sel;
        bus.ld_row   = 2'(row);
        bus.ld_data  = d;
        step();
        bus.ld_valid = 1'b0;
        model_write(sel, row, d);
    endtask

    task automatic check_quiet(input string name);
        check(name, {bus.a_edge, bus.b_edge, bus.edge_valid, bus.acc_clear,
                     bus.done, bus.start_err, bus.busy, bus.ld_ready},
              {{(2*N*DW){1'b0}}, 6'b000001});
    endtask

    // Start a run; stalls come from an edge window (offset from the start edge)
    // and a random percentage. poke drives loads/starts during the run.
    task automatic run(input int stall_pct, input int win_lo, input int win_hi,
                       input bit poke, input int abort_after);
        int c, e, idx;
        bit stl;
        bus.start = 1'b1;
        c = cyc + 1;
        if (!all_loaded()) begin
            push(EV_ERR, c, 0);
            step();
            bus.start = 1'b0;
            check("busy_after_reject", bus.busy, 1'b0);
            return;
        end
        step();
        bus.start = 1'b0;
        idx = 0;
        while (idx < STREAM_BEATS + 2) begin
            e   = cyc + 1;
            stl = ((e - c >= win_lo) && (e - c <= win_hi)) || ($urandom_range(99) < stall_pct);
            bus.feed_stall = stl;
            if (poke) begin
                bus.ld_valid = 1'b1;
                bus.ld_sel   = 1'($urandom_range(1));
                bus.ld_row   = 2'($urandom_range(2));
                bus.ld_data  = (N*DW)'($urandom);
                bus.start    = 1'b1;
                check("ld_ready_busy", bus.ld_ready, 1'b0);
            end
            if (idx < STREAM_BEATS + 1) begin
                if (!stl) begin
                    push(idx == 0 ? EV_CLEAR : EV_BEAT, e, idx - 1);
                    idx++;
                end
            end else begin
                push(EV_DONE, e, 0);
                idx++;
            end
            step();
            bus.ld_valid = 1'b0;
            bus.start    = 1'b0;
            if (abort_after >= 0 && idx == abort_after) begin
                @(negedge clk);
                #1 reset = 1'b1;
                #1 check_quiet("reset_mid_run");
                sb.delete();
                model_clear();
                bus.feed_stall = 1'b0;
                #1 reset = 1'b0;
                step();
                return;
            end
        end
        bus.feed_stall = 1'b0;
    endtask

    initial begin
        logic [N*DW-1:0] d;
        bus.ld_valid   = 1'b0;
        bus.ld_sel     = 1'b0;
        bus.ld_row     = '0;
        bus.ld_data    = '0;
        bus.start      = 1'b0;
        bus.feed_stall = 1'b0;
        reset          = 1'b1;
        model_clear();
        #12;
        check_quiet("reset_state");
        #1 reset = 1'b0;
        step();

        // A only loaded: start is rejected
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) d[c*DW +: DW] = DW'(3 * r + c + 1);
            load_row(LD_SEL_A, r, d);
        end
        run(0, 0, -1, 1'b0, -1);

        // B rows 0,1 plus an out-of-range row 3: still rejected
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < N; c++) d[c*DW +: DW] = DW'(c == r);
            load_row(LD_SEL_B, r, d);
        end
        load_row(LD_SEL_B, 3, {(N*DW){1'b1}});
        run(0, 0, -1, 1'b0, -1);

        // last row loaded in the same cycle as start: start sees old masks
        for (int c = 0; c < N; c++) d[c*DW +: DW] = DW'(c == 2);
        bus.ld_valid = 1'b1;
        bus.ld_sel   = LD_SEL_B;
        bus.ld_row   = 2'd2;
        bus.ld_data  = d;
        bus.start    = 1'b1;
        push(EV_ERR, cyc + 1, 0);
        step();
        bus.ld_valid = 1'b0;
        bus.start    = 1'b0;
        model_write(LD_SEL_B, 2, d);

        run(0, 0, -1, 1'b0, -1);           // A=1..9, B=I
        run(0, 5, 6, 1'b0, -1);            // two-cycle stall at beat t=3
        run(0, 0, -1, 1'b1, -1);           // back-to-back, loads/starts while busy
        run(0, 0, -1, 1'b0, -1);

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 1 + $urandom_range(5); k++)
                load_row(1'($urandom_range(1)), $urandom_range(3), (N*DW)'($urandom));
            run(30, 0, -1, 1'($urandom_range(1)), -1);
        end

        run(0, 0, -1, 1'b0, 6);            // reset right after beat t=4
        run(0, 0, -1, 1'b0, -1);           // masks cleared: rejected

        for (int r = 0; r < N; r++) begin
            load_row(LD_SEL_A, r, (N*DW)'($urandom));
            load_row(LD_SEL_B, r, (N*DW)'($urandom));
        end
        run(20, 0, -1, 1'b0, -1);

        repeat (4) step();
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
